// File: rtl/conv_input_loader.sv
// Input loader for a conv CIM layer: streams activations into the vertical tiles' input registers,
// then starts the array. Optional macro CONV_INPUT_LOADER_ZERO_PAD_EN zero-fills the last tile.
module conv_input_loader #(
    parameter int unsigned input_size    = 201,
    parameter int unsigned xbar_size     = 256,
    parameter int unsigned datatype_size = 8,
    parameter int unsigned v_cim_tiles   = (input_size + xbar_size - 1) / xbar_size
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    output logic                         o_busy,
    input  logic                         i_valid,
    input  logic [datatype_size-1:0]     i_data,
    output logic                         o_ready,
    input  logic                         i_cim_busy,
    output logic [v_cim_tiles-1:0]       o_cim_we,
    output logic [$clog2(xbar_size)-1:0] o_cim_addr,
    output logic [datatype_size-1:0]     o_cim_data,
    output logic                         o_cim_start
);

    localparam int unsigned AddrW = $clog2(xbar_size);
    localparam int unsigned TileW = $clog2(v_cim_tiles) + 1;
    localparam int unsigned CntW  = $clog2(input_size) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StLoad,
`ifdef CONV_INPUT_LOADER_ZERO_PAD_EN
        StPad,
`endif
        StStart
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    input_count_q, input_count_d;
    logic [AddrW-1:0]   cim_addr_q, cim_addr_d;
    logic [TileW-1:0]   tile_count_q, tile_count_d;
    logic               last_row;
    logic               wr_en;

    assign last_row = (cim_addr_q == AddrW'(xbar_size - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            input_count_q <= '0;
            cim_addr_q    <= '0;
            tile_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            input_count_q <= input_count_d;
            cim_addr_q    <= cim_addr_d;
            tile_count_q  <= tile_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        input_count_d = input_count_q;
        cim_addr_d    = cim_addr_q;
        tile_count_d  = tile_count_q;
        o_busy        = 1'b0;
        o_ready       = 1'b0;
        o_cim_start   = 1'b0;
        o_cim_data    = '0;
        wr_en         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d = i_cim_busy ? StWait : StLoad;
                end
            end
            StWait: begin
                o_busy = 1'b1;
                if (!i_cim_busy) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                o_busy  = 1'b1;
                o_ready = 1'b1;
                if (i_valid) begin
                    wr_en         = 1'b1;
                    o_cim_data    = i_data;
                    input_count_d = input_count_q + CntW'(1);
                    if (last_row) begin
                        cim_addr_d   = '0;
                        tile_count_d = tile_count_q + TileW'(1);
                    end else begin
                        cim_addr_d = cim_addr_q + AddrW'(1);
                    end
                    if (input_count_q == CntW'(input_size - 1)) begin
`ifdef CONV_INPUT_LOADER_ZERO_PAD_EN
                        state_d = last_row ? StStart : StPad;
`else
                        state_d = StStart;
`endif
                    end
                end
            end
`ifdef CONV_INPUT_LOADER_ZERO_PAD_EN
            StPad: begin
                o_busy = 1'b1;
                wr_en  = 1'b1;
                // tile_count stays on the last tile so it never points past the array
                if (last_row) begin
                    cim_addr_d = '0;
                    state_d    = StStart;
                end else begin
                    cim_addr_d = cim_addr_q + AddrW'(1);
                end
            end
`endif
            StStart: begin
                o_busy      = 1'b1;
                o_cim_start = 1'b1;
                if (i_cim_busy) begin
                    state_d       = StIdle;
                    input_count_d = '0;
                    cim_addr_d    = '0;
                    tile_count_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_cim_we   = '0;
        o_cim_addr = '0;
        if (wr_en) begin
            o_cim_addr = cim_addr_q;
            for (int t = 0; t < v_cim_tiles; t++) begin
                o_cim_we[t] = (tile_count_q == TileW'(t));
            end
        end
    end

endmodule

// File: doc/conv_input_loader.md
Name: conv_input_loader

Overview:
- Input side of a conv CIM layer: accepts the serial activation stream from the previous layer's functional unit and writes it into the crossbar input registers of the layer's vertical CIM tiles.
- Fills the tiles address-by-address and tile-by-tile, then issues a start to the CIM array.
- Reports busy to the previous layer, which sees it on its next-busy input.

Parameters:
- input_size, 201, number of activations per input vector
- xbar_size, 256, crossbar rows per tile
- datatype_size, 8, activation width in bits
- v_cim_tiles, (input_size+xbar_size-1)/xbar_size, vertical tiles (ceiled division)

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- i_start  in  1  previous layer has data ready to stream
- o_busy  out  1  loader occupied; previous layer must not start a new transfer
- i_valid  in  1  i_data valid this cycle
- i_data  in  datatype_size  activation value
- o_ready  out  1  loader accepts i_data this cycle
- i_cim_busy  in  1  CIM array computing; input registers must not be written
- o_cim_we  out  v_cim_tiles  one-hot per-tile write enable
- o_cim_addr  out  $clog2(xbar_size)  row address within the selected tile
- o_cim_data  out  datatype_size  write data
- o_cim_start  out  1  start CIM computation

Behaviour:
- Reset (rst=1 at a clk edge), including mid-transfer:
  - state returns to S_IDLE
  - input_count, cim_addr and tile_count are cleared to 0
  - all outputs are 0: o_busy, o_ready, o_cim_we, o_cim_addr, o_cim_start, o_cim_data
- Outputs are decoded combinationally from state and counters. Write latency is 0: an accepted beat appears on o_cim_* in the same cycle.
- Accept condition: i_valid & o_ready.
- S_IDLE:
  - o_busy=0, o_ready=0.
  - i_start=1 and i_cim_busy=1 -> S_WAIT.
  - i_start=1 and i_cim_busy=0 -> S_LOAD.
  - Otherwise stay in S_IDLE.
- S_WAIT:
  - o_busy=1, o_ready=0.
  - i_cim_busy=0 -> S_LOAD; otherwise stay.
- S_LOAD:
  - o_busy=1, o_ready=1.
  - On accept: o_cim_we[tile_count]=1, o_cim_addr=cim_addr, o_cim_data=i_data.
  - On accept: input_count increments. cim_addr increments; at xbar_size-1 it wraps to 0 and tile_count increments.
  - No accept: counters hold, o_cim_we=0.
  - Accept with input_count==input_size-1 -> S_PAD (feature on) or S_START.
- S_START:
  - o_busy=1, o_ready=0, o_cim_start=1.
  - o_cim_start stays high until i_cim_busy=1 is sampled, then -> S_IDLE with counters cleared.
  - i_cim_busy already high on entry -> exactly one cycle of o_cim_start.
- Ignored inputs:
  - i_valid outside S_LOAD.
  - i_start outside S_IDLE.
- Simultaneous events:
  - i_start and rst together: reset wins.
  - i_cim_busy rising during S_LOAD is a protocol violation and has no defined response; loading continues regardless.
- Counter widths:
  - cim_addr is $clog2(xbar_size) bits.
  - tile_count is $clog2(v_cim_tiles)+1 bits.
  - input_count is $clog2(input_size)+1 bits.
- Tile boundary: when input_size is an exact multiple of xbar_size, the last beat writes tile v_cim_tiles-1 at address xbar_size-1, and tile_count never indexes past v_cim_tiles-1.

Optional Feature:
- Macro: CONV_INPUT_LOADER_ZERO_PAD_EN
- Defined:
  - After the last beat, enter S_PAD with o_ready=0, o_busy=1.
  - S_PAD writes o_cim_data=0 to the remaining rows of the last tile, one row per cycle, from cim_addr up to xbar_size-1.
  - Then -> S_START.
  - If the last beat already filled row xbar_size-1, S_PAD is skipped and the FSM goes directly to S_START.
- Undefined:
  - No S_PAD state; the FSM goes directly S_LOAD -> S_START.
  - Stale rows in the last tile are left untouched.

Test Plan:
Parameters for all scenarios: input_size=5, xbar_size=4, v_cim_tiles=2.
1. Reset then idle: o_busy, o_ready, o_cim_we, o_cim_start all 0; i_valid pulses are ignored (no write).
2. i_start with i_cim_busy=0, then 5 consecutive beats 0x11..0x15:
   - writes: tile0 addr0..3 = 0x11..0x14, then tile1 addr0 = 0x15 (o_cim_we=2'b10)
   - next cycle o_cim_start=1
   - i_cim_busy=1 the cycle after -> S_IDLE, o_busy=0
3. i_valid toggling 1,0,1,0 during S_LOAD: writes occur only on valid cycles; addresses contiguous; 5 writes total.
4. i_start while i_cim_busy=1 for 3 cycles: o_busy=1, o_ready=0 for those cycles; loading begins the cycle after i_cim_busy falls.
5. rst asserted after 3 accepted beats: next cycle in S_IDLE with all outputs 0; a new i_start restarts at tile0 addr0.
6. CONV_INPUT_LOADER_ZERO_PAD_EN defined, scenario 2 stimulus:
   - after the 0x15 write, three cycles write tile1 addr1..3 = 0
   - then o_cim_start=1
